sdram_pattern_tester: RTL and testbench

- Traffic source that sits directly upstream of the SDRAM controller and drives its word-level request interface.
- Writes an address-derived pattern across a configurable address range, reads it back with up to PIPE_DEPTH reads outstanding, and compares each returned word.
- Counts passes and mismatches and packs them into the 16-bit 7-segment debug_number.
- Replaces the single hard-coded write/read check as the board-level memory test.

---
 rtl/sdram_pattern_tester.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// Board-level memory test: writes an address-derived pattern over 0..LAST_ADDR,
// reads it back with up to PIPE_DEPTH reads in flight, and tallies passes and mismatches.
module sdram_pattern_tester #(
  parameter int unsigned           ADDR_WIDTH = 22,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 22'h3FFFFF,
  parameter int unsigned           PIPE_DEPTH = 4,
  parameter logic [15:0]           SEED       = 16'hA55A,
  parameter bit                    LOOP       = 1'b1
) (
  input  logic                  dram_clk,
  input  logic                  reset_n,
  input  logic                  ctrl_init_done,
  output logic                  req,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [15:0]           req_data,
  input  logic                  req_ready,
  input  logic                  rd_valid,
  input  logic [15:0]           rd_data,
  output logic                  pass_done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [15:0]           debug_number,
  output logic [2:0]            o_dbg_state,
  output logic [15:0]           o_pass_count,
  output logic [15:0]           o_error_count
);

  localparam int unsigned      PTR_W   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PIPE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr, w_cur_addr_nxt;
  logic                  r_req, w_req_nxt;
  logic                  r_req_write, w_req_write_nxt;
  logic [ADDR_WIDTH-1:0] r_req_addr, w_req_addr_nxt;
  logic [15:0]           r_req_data, w_req_data_nxt;
  logic                  r_pass_done, w_pass_done_nxt;

  logic                  w_accept, w_push, w_pop, w_fifo_empty, w_mismatch;
  logic [ADDR_WIDTH-1:0] r_fifo [PIPE_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_outstanding;
  logic [ADDR_WIDTH-1:0] w_head;
  logic [15:0]           r_pass_count, r_err_count, r_debug;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic [7:0]            w_err_sat8;

  function automatic logic [15:0] pat(input logic [15:0] a16, input logic [7:0] p8);
    return a16 ^ {p8, p8} ^ SEED;
  endfunction

  // Handshake: a request transfers on a rising edge where req && req_ready; req and its
  // payload are held until then, and are dropped for one cycle after each transfer.
  assign w_accept     = r_req && req_ready;
  assign w_fifo_empty = (r_outstanding == '0);
  assign w_pop        = rd_valid && !w_fifo_empty;
  assign w_head       = r_fifo[r_rd_ptr];
  // Read data with nothing outstanding is a protocol violation and counts as a mismatch.
  assign w_mismatch   = rd_valid &&
                        (w_fifo_empty || (rd_data != pat(w_head[15:0], r_pass_count[7:0])));
  assign w_err_sat8   = (r_err_count[15:8] != 8'd0) ? 8'hFF : r_err_count[7:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_addr_nxt  = r_cur_addr;
    w_req_nxt       = r_req;
    w_req_write_nxt = r_req_write;
    w_req_addr_nxt  = r_req_addr;
    w_req_data_nxt  = r_req_data;
    w_pass_done_nxt = 1'b0;
    w_push          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ctrl_init_done) begin
          w_state_nxt    = S_WRITE;
          w_cur_addr_nxt = '0;
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          w_req_nxt = 1'b0;
          if (r_cur_addr == LAST_ADDR) begin
            w_state_nxt    = S_READ;
            w_cur_addr_nxt = '0;
          end else begin
            w_cur_addr_nxt = r_cur_addr + ADDR_WIDTH'(1);
          end
        end else if (!r_req) begin
          w_req_nxt       = 1'b1;
          w_req_write_nxt = 1'b1;
          w_req_addr_nxt  = r_cur_addr;
          w_req_data_nxt  = pat(r_cur_addr[15:0], r_pass_count[7:0]);
        end
      end
      S_READ: begin
        if (w_accept) begin
          w_req_nxt = 1'b0;
          w_push    = 1'b1;
          if (r_cur_addr == LAST_ADDR) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_cur_addr_nxt = r_cur_addr + ADDR_WIDTH'(1);
          end
        end else if (!r_req && (r_outstanding < DEPTH_C)) begin
          // Outstanding cannot grow while req is pending, so the FIFO never overflows.
          w_req_nxt       = 1'b1;
          w_req_write_nxt = 1'b0;
          w_req_addr_nxt  = r_cur_addr;
          w_req_data_nxt  = 16'd0;
        end
      end
      S_DRAIN: begin
        if (w_fifo_empty && !rd_valid) begin
          w_pass_done_nxt = 1'b1;
          w_cur_addr_nxt  = '0;
          w_state_nxt     = LOOP ? S_WRITE : S_DONE;
        end
      end
      S_DONE: begin
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dram_clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_req       <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= 16'd0;
      r_pass_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_req       <= w_req_nxt;
      r_req_write <= w_req_write_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_data  <= w_req_data_nxt;
      r_pass_done <= w_pass_done_nxt;
    end
  end

  always_ff @(posedge dram_clk) begin
    if (!reset_n) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_outstanding    <= '0;
      r_pass_count     <= 16'd0;
      r_err_count      <= 16'd0;
      r_error          <= 1'b0;
      r_first_err_addr <= '0;
      r_debug          <= 16'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_outstanding <= r_outstanding - CNT_W'(1);
      end
      if (w_pass_done_nxt) r_pass_count <= r_pass_count + 16'd1;
      if (w_mismatch) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        r_error <= 1'b1;
        if (!r_error) r_first_err_addr <= w_pop ? w_head : '0;
      end
      r_debug <= {r_pass_count[7:0], w_err_sat8};
    end
  end

  always_ff @(posedge dram_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_req_addr;
  end

  assign req            = r_req;
  assign req_write      = r_req_write;
  assign req_addr       = r_req_addr;
  assign req_data       = r_req_data;
  assign pass_done      = r_pass_done;
  assign error          = r_error;
  assign first_err_addr = r_first_err_addr;
  assign debug_number   = r_debug;
  assign o_dbg_state    = r_state;
  assign o_pass_count   = r_pass_count;
  assign o_error_count  = r_err_count;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: an ideal word memory with configurable latency and
// backpressure, serving either a single-pass instance or a looping instance.
`timescale 1ns/1ps
module tb_sdram_pattern_tester;

  localparam int            AW     = 22;
  localparam int            NWORDS = 8;
  localparam logic [15:0]   SEED   = 16'hA55A;
  localparam logic [2:0]    ST_IDLE = 3'd0, ST_WRITE = 3'd1, ST_DONE = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n   = 1'b0;
  logic init_done = 1'b0;
  logic sel       = 1'b0;

  // memory-side drive
  logic        m_ready    = 1'b0;
  logic        m_rv_model = 1'b0;
  logic [15:0] m_rd_data  = 16'd0;
  logic        inj_rv     = 1'b0;
  logic [15:0] inj_data   = 16'd0;
  logic        w_rv;
  logic [15:0] w_rd_data;
  assign w_rv      = m_rv_model | inj_rv;
  assign w_rd_data = inj_rv ? inj_data : m_rd_data;

  logic          d0_req, d0_wr, d0_pd, d0_err;
  logic [AW-1:0] d0_addr, d0_ferr;
  logic [15:0]   d0_data, d0_dbg, d0_pc, d0_ec;
  logic [2:0]    d0_st;
  logic          d1_req, d1_wr, d1_pd, d1_err;
  logic [AW-1:0] d1_addr, d1_ferr;
  logic [15:0]   d1_data, d1_dbg, d1_pc, d1_ec;
  logic [2:0]    d1_st;

  sdram_pattern_tester #(.ADDR_WIDTH(AW), .LAST_ADDR(22'd7), .PIPE_DEPTH(4),
                         .SEED(16'hA55A), .LOOP(1'b0)) u_dut (
    .dram_clk(clk), .reset_n(reset_n), .ctrl_init_done(init_done & ~sel),
    .req(d0_req), .req_write(d0_wr), .req_addr(d0_addr), .req_data(d0_data),
    .req_ready(m_ready & ~sel), .rd_valid(w_rv & ~sel), .rd_data(w_rd_data),
    .pass_done(d0_pd), .error(d0_err), .first_err_addr(d0_ferr), .debug_number(d0_dbg),
    .o_dbg_state(d0_st), .o_pass_count(d0_pc), .o_error_count(d0_ec));

  sdram_pattern_tester #(.ADDR_WIDTH(AW), .LAST_ADDR(22'd7), .PIPE_DEPTH(4),
                         .SEED(16'hA55A), .LOOP(1'b1)) u_dut_loop (
    .dram_clk(clk), .reset_n(reset_n), .ctrl_init_done(init_done & sel),
    .req(d1_req), .req_write(d1_wr), .req_addr(d1_addr), .req_data(d1_data),
    .req_ready(m_ready & sel), .rd_valid(w_rv & sel), .rd_data(w_rd_data),
    .pass_done(d1_pd), .error(d1_err), .first_err_addr(d1_ferr), .debug_number(d1_dbg),
    .o_dbg_state(d1_st), .o_pass_count(d1_pc), .o_error_count(d1_ec));

  logic          m_req, m_write, m_pd, m_err;
  logic [AW-1:0] m_addr, m_ferr;
  logic [15:0]   m_data, m_dbg, m_pc, m_ec;
  logic [2:0]    m_state;
  assign m_req   = sel ? d1_req  : d0_req;
  assign m_write = sel ? d1_wr   : d0_wr;
  assign m_addr  = sel ? d1_addr : d0_addr;
  assign m_data  = sel ? d1_data : d0_data;
  assign m_pd    = sel ? d1_pd   : d0_pd;
  assign m_err   = sel ? d1_err  : d0_err;
  assign m_ferr  = sel ? d1_ferr : d0_ferr;
  assign m_dbg   = sel ? d1_dbg  : d0_dbg;
  assign m_pc    = sel ? d1_pc   : d0_pc;
  assign m_ec    = sel ? d1_ec   : d0_ec;
  assign m_state = sel ? d1_st   : d0_st;

  // memory model state and observation log
  int            lat = 3;
  int unsigned   bp_pct = 0;
  bit            force_stall = 1'b0;
  logic [15:0]   mem  [0:NWORDS-1];
  logic [15:0]   flip [0:NWORDS-1];
  int            due_q[$];
  logic [15:0]   dat_q[$];
  logic [38:0]   log_q[$];
  logic [38:0]   exp_q[$];
  int cyc = 0, model_out = 0, max_out = 0, rd_acc = 0, rv_count = 0, pd_count = 0;
  int reads_before_rv = 0, stall_viol = 0, full_req_viol = 0;
  bit seen_rv = 1'b0, prev_req = 1'b0, prev_acc = 1'b0, prev_write = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   prev_data = 16'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // Everything is observed and driven on the falling edge; an accept recorded here
  // happens on the following rising edge, which is rising edge number cyc.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      due_q.delete();
      dat_q.delete();
      model_out  = 0;
      m_rv_model = 1'b0;
      m_ready    = 1'b0;
      prev_req   = 1'b0;
    end else begin
      if (prev_req && !prev_acc &&
          (!m_req || m_addr !== prev_addr || m_data !== prev_data || m_write !== prev_write))
        stall_viol++;
      if (m_req && model_out >= 4) full_req_viol++;
      if (m_pd) pd_count++;
      if (force_stall)      m_ready = 1'b0;
      else if (bp_pct == 0) m_ready = 1'b1;
      else                  m_ready = ($urandom_range(99, 0) >= bp_pct);
      m_rv_model = 1'b0;
      m_rd_data  = 16'd0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        m_rv_model = 1'b1;
        m_rd_data  = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
        model_out--;
        rv_count++;
        seen_rv = 1'b1;
      end
      prev_acc = m_req && m_ready;
      if (prev_acc) begin
        log_q.push_back({m_write, m_addr, m_data});
        if (m_write) begin
          mem[m_addr[2:0]] = m_data;
        end else begin
          due_q.push_back(cyc + lat);
          dat_q.push_back(mem[m_addr[2:0]] ^ flip[m_addr[2:0]]);
          model_out++;
          rd_acc++;
          if (!seen_rv) reads_before_rv++;
        end
      end
      if (model_out > max_out) max_out = model_out;
      prev_req   = m_req;
      prev_addr  = m_addr;
      prev_data  = m_data;
      prev_write = m_write;
    end
  end

  // reference model
  function automatic logic [15:0] pat_of(input int a, input int p);
    logic [15:0] a16;
    logic [7:0]  p8;
    a16 = 16'(a);
    p8  = 8'(p);
    return a16 ^ {p8, p8} ^ SEED;
  endfunction

  function automatic void build_exp(input int p);
    for (int a = 0; a < NWORDS; a++) exp_q.push_back({1'b1, AW'(a), pat_of(a, p)});
    for (int a = 0; a < NWORDS; a++) exp_q.push_back({1'b0, AW'(a), 16'h0000});
  endfunction

  function automatic int seq_diffs(input bit exact);
    int d = 0;
    if (exact ? (log_q.size() != exp_q.size()) : (log_q.size() < exp_q.size())) d++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      if (log_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // driver tasks
  task automatic clear_model();
    log_q.delete(); exp_q.delete(); due_q.delete(); dat_q.delete();
    for (int a = 0; a < NWORDS; a++) begin mem[a] = 16'd0; flip[a] = 16'd0; end
    model_out = 0; max_out = 0; rd_acc = 0; rv_count = 0; pd_count = 0;
    reads_before_rv = 0; stall_viol = 0; full_req_viol = 0;
    seen_rv = 1'b0; prev_req = 1'b0; prev_acc = 1'b0;
    lat = 3; bp_pct = 0; force_stall = 1'b0;
  endtask

  task automatic do_reset();
    init_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_model();
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (m_state == st) begin ok = 1'b1; break; end
    end
  endtask

  // tests
  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    n_tests++; if (m_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", m_state, ST_IDLE); end
    n_tests++; if ({m_req, m_write, m_pd, m_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {m_req, m_write, m_pd, m_err}); end
    n_tests++; if (m_addr !== '0 || m_data !== 16'd0) begin n_fail++; $display("FAIL reset_payload: got addr %0h data %0h expected 0 0", m_addr, m_data); end
    n_tests++; if (m_ferr !== '0 || m_dbg !== 16'd0) begin n_fail++; $display("FAIL reset_err_dbg: got ferr %0h dbg %0h expected 0 0", m_ferr, m_dbg); end
  endtask

  task automatic test_clean_pass();
    bit ok;
    logic [38:0] e0, e1;
    sel = 1'b0;
    do_reset();
    build_exp(0);
    init_done = 1'b1;
    wait_state(ST_DONE, 2000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL clean_timeout: got state %0d expected %0d", m_state, ST_DONE); end
    init_done = 1'b0;
    repeat (3) @(negedge clk);
    init_done = 1'b1;
    repeat (3) @(negedge clk);
    e0 = (log_q.size() > 0) ? log_q[0] : '0;
    e1 = (log_q.size() > 1) ? log_q[1] : '0;
    n_tests++; if (e0[15:0] !== 16'hA55A) begin n_fail++; $display("FAIL clean_first_wdata: got %0h expected a55a", e0[15:0]); end
    n_tests++; if (e1[15:0] !== 16'hA55B) begin n_fail++; $display("FAIL clean_second_wdata: got %0h expected a55b", e1[15:0]); end
    n_tests++; if (seq_diffs(1'b1) !== 0) begin n_fail++; $display("FAIL clean_sequence: got %0d diffs (%0d reqs) expected 0 (%0d reqs)", seq_diffs(1'b1), log_q.size(), exp_q.size()); end
    n_tests++; if (pd_count !== 1) begin n_fail++; $display("FAIL clean_pass_done: got %0d pulse cycles expected 1", pd_count); end
    n_tests++; if (m_dbg !== 16'h0100) begin n_fail++; $display("FAIL clean_debug: got %0h expected 0100", m_dbg); end
    n_tests++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL clean_error: got %b expected 0", m_err); end
    n_tests++; if (m_state !== ST_DONE || m_req !== 1'b0) begin n_fail++; $display("FAIL clean_done_hold: got state %0d req %b expected %0d 0", m_state, m_req, ST_DONE); end
    init_done = 1'b0;
  endtask

  task automatic test_bit_flip();
    bit ok;
    sel = 1'b0;
    do_reset();
    flip[5] = 16'h0001;
    init_done = 1'b1;
    wait_state(ST_DONE, 2000, ok);
    repeat (3) @(negedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL flip_timeout: got state %0d expected %0d", m_state, ST_DONE); end
    n_tests++; if (m_err !== 1'b1) begin n_fail++; $display("FAIL flip_error: got %b expected 1", m_err); end
    n_tests++; if (m_ferr !== AW'(5)) begin n_fail++; $display("FAIL flip_first_addr: got %0d expected 5", m_ferr); end
    n_tests++; if (m_dbg !== 16'h0101) begin n_fail++; $display("FAIL flip_debug: got %0h expected 0101", m_dbg); end
    init_done = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    sel = 1'b0;
    do_reset();
    build_exp(0);
    init_done = 1'b1;
    n = 0;
    while (log_q.size() < 3 && n < 500) begin @(negedge clk); n++; end
    force_stall = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++; if (m_req !== 1'b1 || m_write !== 1'b1) begin n_fail++; $display("FAIL bp_stalled_req: got req %b write %b expected 1 1", m_req, m_write); end
    force_stall = 1'b0;
    bp_pct = 50;
    wait_state(ST_DONE, 3000, ok);
    repeat (3) @(negedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got state %0d expected %0d", m_state, ST_DONE); end
    n_tests++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_viol); end
    n_tests++; if (seq_diffs(1'b1) !== 0) begin n_fail++; $display("FAIL bp_sequence: got %0d diffs expected 0", seq_diffs(1'b1)); end
    n_tests++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL bp_error: got %b expected 0", m_err); end
    init_done = 1'b0;
  endtask

  task automatic test_deep_latency();
    bit ok;
    sel = 1'b0;
    do_reset();
    build_exp(0);
    lat = 20;
    init_done = 1'b1;
    wait_state(ST_DONE, 3000, ok);
    repeat (3) @(negedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL lat_timeout: got state %0d expected %0d", m_state, ST_DONE); end
    n_tests++; if (reads_before_rv !== 4) begin n_fail++; $display("FAIL lat_reads_before_data: got %0d expected 4", reads_before_rv); end
    n_tests++; if (max_out !== 4) begin n_fail++; $display("FAIL lat_max_outstanding: got %0d expected 4", max_out); end
    n_tests++; if (full_req_viol !== 0) begin n_fail++; $display("FAIL lat_req_when_full: got %0d cycles expected 0", full_req_viol); end
    n_tests++; if (seq_diffs(1'b1) !== 0 || rv_count !== NWORDS) begin n_fail++; $display("FAIL lat_sequence: got %0d diffs %0d returns expected 0 %0d", seq_diffs(1'b1), rv_count, NWORDS); end
    n_tests++; if (m_err !== 1'b0 || m_dbg !== 16'h0100) begin n_fail++; $display("FAIL lat_result: got err %b dbg %0h expected 0 0100", m_err, m_dbg); end
    init_done = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int n;
    sel = 1'b0;
    do_reset();
    lat = 20;
    init_done = 1'b1;
    n = 0;
    while (rd_acc < 3 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    n_tests++; if (rd_acc !== 3) begin n_fail++; $display("FAIL rst_setup_reads: got %0d expected 3", rd_acc); end
    init_done = 1'b0;
    reset_n   = 1'b0;
    inj_rv    = 1'b1;
    inj_data  = 16'($urandom);
    @(negedge clk);
    reset_n = 1'b1;
    inj_rv  = 1'b0;
    n_tests++; if (m_state !== ST_IDLE || {m_req, m_write, m_pd, m_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_flags: got state %0d flags %b expected %0d 0000", m_state, {m_req, m_write, m_pd, m_err}, ST_IDLE); end
    n_tests++; if (m_addr !== '0 || m_data !== 16'd0 || m_ferr !== '0 || m_dbg !== 16'd0 || m_ec !== 16'd0) begin n_fail++; $display("FAIL rst_mid_values: got addr %0h data %0h ferr %0h dbg %0h ec %0d expected all 0", m_addr, m_data, m_ferr, m_dbg, m_ec); end
    clear_model();
    @(negedge clk);
    inj_rv   = 1'b1;
    inj_data = 16'($urandom);
    @(negedge clk);
    inj_rv = 1'b0;
    n_tests++; if (m_err !== 1'b1 || m_ec !== 16'd1 || m_ferr !== '0) begin n_fail++; $display("FAIL rst_late_rv: got err %b ec %0d ferr %0h expected 1 1 0", m_err, m_ec, m_ferr); end
    @(negedge clk);
    n_tests++; if (m_dbg !== 16'h0001) begin n_fail++; $display("FAIL rst_late_dbg: got %0h expected 0001", m_dbg); end
    build_exp(0);
    init_done = 1'b1;
    wait_state(ST_DONE, 2000, ok);
    repeat (3) @(negedge clk);
    n_tests++; if (!ok || seq_diffs(1'b1) !== 0) begin n_fail++; $display("FAIL rst_fresh_pass: got ok %b diffs %0d expected 1 0", ok, seq_diffs(1'b1)); end
    n_tests++; if (m_dbg !== 16'h0101 || m_ec !== 16'd1) begin n_fail++; $display("FAIL rst_fresh_dbg: got %0h ec %0d expected 0101 1", m_dbg, m_ec); end
    init_done = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      bit ok;
      int nerr;
      logic [AW-1:0] first;
      sel = 1'b0;
      do_reset();
      build_exp(0);
      lat    = $urandom_range(8, 1);
      bp_pct = $urandom_range(60, 0);
      nerr   = 0;
      first  = '0;
      for (int a = 0; a < NWORDS; a++) begin
        if ($urandom_range(3, 0) == 0) begin
          flip[a] = 16'h0001 << $urandom_range(15, 0);
          if (nerr == 0) first = AW'(a);
          nerr++;
        end
      end
      init_done = 1'b1;
      wait_state(ST_DONE, 3000, ok);
      repeat (3) @(negedge clk);
      n_tests++; if (!ok || seq_diffs(1'b1) !== 0) begin n_fail++; $display("FAIL rand_sequence[%0d]: got ok %b diffs %0d expected 1 0", it, ok, seq_diffs(1'b1)); end
      n_tests++; if (m_ec !== 16'(nerr) || m_err !== (nerr != 0)) begin n_fail++; $display("FAIL rand_errors[%0d]: got ec %0d err %b expected %0d %b", it, m_ec, m_err, nerr, nerr != 0); end
      n_tests++; if (m_ferr !== first) begin n_fail++; $display("FAIL rand_first_addr[%0d]: got %0d expected %0d", it, m_ferr, first); end
      n_tests++; if (m_dbg !== {8'h01, 8'(nerr)}) begin n_fail++; $display("FAIL rand_debug[%0d]: got %0h expected %0h", it, m_dbg, {8'h01, 8'(nerr)}); end
      init_done = 1'b0;
    end
  endtask

  task automatic test_loop();
    int n;
    logic [38:0] e;
    sel = 1'b1;
    do_reset();
    build_exp(0);
    build_exp(1);
    bp_pct = 20;
    init_done = 1'b1;
    n = 0;
    while (pd_count < 2 && n < 4000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    e = (log_q.size() > 16) ? log_q[16] : '0;
    n_tests++; if (pd_count !== 2) begin n_fail++; $display("FAIL loop_passes: got %0d expected 2", pd_count); end
    n_tests++; if (e[15:0] !== 16'hA45B || e[38] !== 1'b1) begin n_fail++; $display("FAIL loop_pass2_wdata: got %0h expected a45b", e[15:0]); end
    n_tests++; if (seq_diffs(1'b0) !== 0) begin n_fail++; $display("FAIL loop_sequence: got %0d diffs expected 0", seq_diffs(1'b0)); end
    n_tests++; if (m_dbg !== 16'h0200 || m_pc !== 16'd2) begin n_fail++; $display("FAIL loop_debug: got %0h pc %0d expected 0200 2", m_dbg, m_pc); end
    n_tests++; if (m_state !== ST_WRITE || m_err !== 1'b0) begin n_fail++; $display("FAIL loop_state: got %0d err %b expected %0d 0", m_state, m_err, ST_WRITE); end
    init_done = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_bit_flip();
    test_backpressure();
    test_deep_latency();
    test_reset_mid_read();
    test_random();
    test_loop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
